// File: rtl/xif_offload_ctrl.sv
// Core-side CORE-V-XIF offload controller: issue/commit sequencing, outstanding-ID table, result writeback.
// Optional statistics counters enabled by defining XIF_OFFLOAD_STATS_EN.
module xif_offload_ctrl #(
    parameter int X_ID_WIDTH      = 4,
    parameter int X_NUM_RS        = 2,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [31:0]                instr,
    input  logic [X_NUM_RS*XLEN-1:0]   instr_rs,
    input  logic                       instr_kill,
    output logic                       instr_accept,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [31:0]                issue_instr,
    output logic [X_ID_WIDTH-1:0]      issue_id,
    output logic [X_NUM_RS*XLEN-1:0]   issue_rs,
    output logic [X_NUM_RS-1:0]        issue_rs_valid,
    input  logic                       issue_resp_accept,
    input  logic                       issue_resp_writeback,
    output logic                       commit_valid,
    output logic [X_ID_WIDTH-1:0]      commit_id,
    output logic                       commit_kill,
    input  logic                       result_valid,
    output logic                       result_ready,
    input  logic [X_ID_WIDTH-1:0]      result_id,
    input  logic [XLEN-1:0]            result_data,
    input  logic [4:0]                 result_rd,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    output logic [XLEN-1:0]            wb_data,
    input  logic                       wb_ready,
    output logic                       busy,
    output logic                       err_unexpected_id,
    output logic [31:0]                stat_issued,
    output logic [31:0]                stat_killed,
    output logic [31:0]                stat_results
);

    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;
    state_t state, state_nxt;

    logic [MAX_OUTSTANDING-1:0] ent_used;
    logic [MAX_OUTSTANDING-1:0] ent_committed;
    logic [MAX_OUTSTANDING-1:0] ent_wb;
    logic [X_ID_WIDTH-1:0]      ent_id [MAX_OUTSTANDING];

    logic [X_ID_WIDTH-1:0] next_id;
    logic [IDX_W-1:0]      cur_idx;
    logic                  accept_q;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             id_in_use;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             result_fire;

    // Table scan uses registered state only, so a free in this cycle cannot enable an allocate now.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        id_in_use  = 1'b0;
        hit        = 1'b0;
        hit_idx    = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!ent_used[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_used[i] && ent_id[i] == next_id)
                id_in_use = 1'b1;
            if (ent_used[i] && ent_committed[i] && ent_wb[i] && ent_id[i] == result_id) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        case (state)
            IDLE:    if (instr_valid && free_found && !id_in_use) state_nxt = ISSUE;
            ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign instr_ready  = issue_valid && issue_ready;
    assign instr_accept = instr_ready && issue_resp_accept;
    assign commit_id    = issue_id;
    assign commit_kill  = commit_valid && (instr_kill || !accept_q);
    assign result_ready = !wb_valid || wb_ready;
    assign result_fire  = result_valid && result_ready;
    assign busy         = |ent_used;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            issue_instr    <= '0;
            issue_rs       <= '0;
            issue_id       <= '0;
            issue_rs_valid <= '0;
            next_id        <= '0;
            accept_q       <= 1'b0;
            cur_idx        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == ISSUE) begin
                issue_instr    <= instr;
                issue_rs       <= instr_rs;
                issue_id       <= next_id;
                issue_rs_valid <= '1;
            end
            if (instr_ready) begin
                accept_q <= issue_resp_accept;
                next_id  <= next_id + 1'b1;
                cur_idx  <= free_idx;
            end
        end
    end

    // Allocate, commit-update and result-free always touch distinct entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_used      <= '0;
            ent_committed <= '0;
            ent_wb        <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) ent_id[i] <= '0;
        end else begin
            if (instr_ready) begin
                ent_used[free_idx]      <= 1'b1;
                ent_committed[free_idx] <= 1'b0;
                ent_wb[free_idx]        <= issue_resp_accept && issue_resp_writeback;
                ent_id[free_idx]        <= issue_id;
            end
            if (commit_valid) begin
                if (commit_kill || !ent_wb[cur_idx])
                    ent_used[cur_idx] <= 1'b0;
                else
                    ent_committed[cur_idx] <= 1'b1;
            end
            if (result_fire && hit) begin
                ent_used[hit_idx]      <= 1'b0;
                ent_committed[hit_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid          <= 1'b0;
            wb_rd             <= '0;
            wb_data           <= '0;
            err_unexpected_id <= 1'b0;
        end else if (result_fire && hit) begin
            wb_valid <= 1'b1;
            wb_rd    <= result_rd;
            wb_data  <= result_data;
        end else begin
            if (wb_ready)    wb_valid          <= 1'b0;
            if (result_fire) err_unexpected_id <= 1'b1;
        end
    end

`ifdef XIF_OFFLOAD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_killed  <= '0;
            stat_results <= '0;
        end else begin
            if (instr_ready && stat_issued != '1)  stat_issued  <= stat_issued + 1'b1;
            if (commit_kill && stat_killed != '1)  stat_killed  <= stat_killed + 1'b1;
            if (result_fire && stat_results != '1) stat_results <= stat_results + 1'b1;
        end
    end
`else
    assign stat_issued  = '0;
    assign stat_killed  = '0;
    assign stat_results = '0;
`endif

endmodule
